latch_wr_seq: RTL

Write sequencer that sits directly upstream of the gated D-latch bank and drives its `d` and `e` inputs. On a request it:
- presents the data with a programmable setup window,
- opens the latch enable for a programmable pulse width,
- holds the data for a programmable hold window,
- reads the latch `q` outputs back through a two-flop synchronizer and reports completion and mismatch.

It guarantees the latch never sees `d` change while `e` is high.

---
 rtl/latch_pkg.sv | 25 ++
 rtl/latch_wr_seq_if.sv | 23 ++
 rtl/latch_wr_seq_sync2.sv | 21 ++
 rtl/latch_wr_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/latch_pkg.sv
// Shared types and constants for the latch write sequencer.
package latch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        CHECK
    } wr_state_t;

    localparam int unsigned SYNC_CYC = 2;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned x);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (x > m) m = x;
        return m;
    endfunction

endpackage

// File: rtl/latch_wr_seq_if.sv
// Request/latch-bank bundle between the write sequencer and its environment.
interface latch_wr_seq_if #(
    parameter int unsigned W = 4
);
    logic         req;
    logic [W-1:0] wdata;
    logic [W-1:0] q_fb;
    logic [W-1:0] d;
    logic         e;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output req, wdata, q_fb,
        input  d, e, busy, done, err
    );

    modport slave (
        input  req, wdata, q_fb,
        output d, e, busy, done, err
    );
endinterface

// File: rtl/latch_wr_seq_sync2.sv
// Two-flop synchronizer, async active-high reset to zero.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/latch_wr_seq.sv
// Write sequencer for a gated D-latch bank: setup, enable pulse, hold, then
// synchronized readback check. d only changes on the accepting edge.
module latch_wr_seq
    import latch_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 3,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic           clk,
    input  logic           r,
    latch_wr_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, SYNC_CYC) + 1);

    wr_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0] d_q, d_nx;
    logic         e_q, e_nx;
    logic         busy_q, busy_nx;
    logic         done_q, done_nx;
    logic         err_q, err_nx;
    logic [W-1:0] q_sync;
    logic         cnt_zero;

    sync2 #(.W(W)) u_sync (
        .clk  (clk),
        .rst  (r),
        .din  (bus.q_fb),
        .dout (q_sync)
    );

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state  <= IDLE;
            cnt    <= '0;
            d_q    <= '0;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            d_q    <= d_nx;
            e_q    <= e_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    // Outputs are registered, so done/err are computed on the edge entering CHECK.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        d_nx     = d_q;
        e_nx     = 1'b0;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    d_nx     = bus.wdata;
                    cnt_nx   = CW'(SETUP_CYC - 1);
                    state_nx = SETUP;
                    busy_nx  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nx = PULSE;
                    e_nx     = 1'b1;
                    cnt_nx   = CW'(PULSE_CYC - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_nx = HOLD;
                    cnt_nx   = CW'(HOLD_CYC - 1);
                end else begin
                    e_nx   = 1'b1;
                    cnt_nx = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nx = SETTLE;
                    cnt_nx   = CW'(SYNC_CYC - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_nx = CHECK;
                    done_nx  = 1'b1;
                    err_nx   = (q_sync != d_q);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            CHECK: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign bus.d    = d_q;
    assign bus.e    = e_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
